// File: rtl/fp_div_normalize_pack.sv
// fp_div_normalize_pack: back end of the floating-point divide path.
//
// Takes the raw quotient mantissa (Q1.(MANT_W-1)), the biased exponent, the
// sign and the special-case flags from the divide front end. It normalizes
// one bit per cycle, rounds to nearest-even and packs an IEEE single or half
// result together with the final exception flags. Only one operation is in
// flight at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   MANT_IN             unsigned quotient mantissa, value in [0,2)
//   EXP_IN              two's-complement biased exponent
//   SIGN_IN             result sign
//   MODE_FP             0 = half, 1 = single
//   FLAGS_IN            [1] invalid, [2] divide-by-zero; other bits ignored
//   out_valid/out_ready result handshake
//   RESULT              packed result; half mode uses [15:0], [31:16] = 0
//   FLAGS_OUT           [0] inexact [1] invalid [2] div-by-zero
//                       [3] underflow [4] overflow
//
// Optional feature macro: FP_DIV_SUBNORMAL_EN
//   Defined   -> tiny results are denormalized (DENORM state) and packed as
//                subnormals; underflow flags only when tiny and inexact.
//   Undefined -> tiny results flush to signed zero.

module fp_div_normalize_pack #(
  parameter int MANT_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] MANT_IN,
  input  logic [9:0]        EXP_IN,
  input  logic              SIGN_IN,
  input  logic              MODE_FP,
  input  logic [4:0]        FLAGS_IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       RESULT,
  output logic [4:0]        FLAGS_OUT
);

  localparam int MSB = MANT_W - 1;
  // Wide enough for EXP_IN minus a full-width normalization shift.
  localparam int EW  = 12;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_DONE, S_DENORM} state_e;

  state_e                state_q, state_d;
  logic [MANT_W-1:0]     mant_q, mant_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic                  mode_q, mode_d;
  logic                  inv_q, inv_d;
  logic                  dbz_q, dbz_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           result_q, result_d;
  logic [4:0]            flags_q, flags_d;
`ifdef FP_DIV_SUBNORMAL_EN
  logic                  sticky_q, sticky_d;
  logic                  tiny_q, tiny_d;
  logic [4:0]            shcnt_q, shcnt_d;
`endif

  logic unused_flags;
  assign unused_flags = ^{FLAGS_IN[4:3], FLAGS_IN[0]};

  logic special, norm_done;
  assign special   = inv_q | dbz_q;
  assign norm_done = (mant_q == '0) | mant_q[MSB] | special;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_NORM;
      S_NORM:  if (norm_done) begin
`ifdef FP_DIV_SUBNORMAL_EN
        state_d = (!special && mant_q != '0 && exp_q <= 12'sd0) ? S_DENORM : S_ROUND;
`else
        state_d = S_ROUND;
`endif
      end
`ifdef FP_DIV_SUBNORMAL_EN
      S_DENORM: if (exp_q == 12'sd1) state_d = S_ROUND;
`endif
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign RESULT    = result_q;
  assign FLAGS_OUT = flags_q;

  // ------------------------------------------------------- round and pack
  logic [23:0]          keep;
  logic                 guard, sticky, round_up, carry, inexact, ovf, is_zero;
  logic [24:0]          sum;
  logic [23:0]          rmant;
  logic signed [EW-1:0] rexp;
  logic [31:0]          inf_w, zero_w, res_pack;
  logic [4:0]           flg_pack;

  always_comb begin
    if (mode_q) begin
      keep   = mant_q[MSB -: 24];
      guard  = mant_q[MSB-24];
      sticky = |mant_q[MSB-25:0];
    end else begin
      keep   = {13'd0, mant_q[MSB -: 11]};
      guard  = mant_q[MSB-11];
      sticky = |mant_q[MSB-12:0];
    end
`ifdef FP_DIV_SUBNORMAL_EN
    sticky = sticky | sticky_q;
`endif
    round_up = guard & (sticky | keep[0]);
    sum      = {1'b0, keep} + {24'd0, round_up};
    // Carry out of the kept field: mantissa becomes 1.0, exponent bumps.
    carry    = mode_q ? sum[24] : sum[11];
    rmant    = carry ? (mode_q ? 24'h80_0000 : 24'h00_0400) : sum[23:0];
    rexp     = carry ? exp_q + 12'sd1 : exp_q;
    inexact  = guard | sticky;
    ovf      = mode_q ? (rexp >= 12'sd255) : (rexp >= 12'sd31);
`ifdef FP_DIV_SUBNORMAL_EN
    is_zero  = (mant_q == '0) && !tiny_q && !sticky_q;
`else
    is_zero  = (mant_q == '0);
`endif
  end

  assign inf_w  = mode_q ? {sign_q, 8'hFF, 23'd0} : {16'd0, sign_q, 5'h1F, 10'd0};
  assign zero_w = mode_q ? {sign_q, 31'd0} : {16'd0, sign_q, 15'd0};

  always_comb begin
    res_pack = '0;
    flg_pack = '0;
    if (inv_q) begin
      res_pack = mode_q ? 32'h7FC0_0000 : 32'h0000_7E00;
      flg_pack = 5'b00010;
    end else if (dbz_q) begin
      res_pack = inf_w;
      flg_pack = 5'b00100;
    end else if (is_zero) begin
      res_pack = zero_w;
    end else if (ovf) begin
      res_pack = inf_w;
      flg_pack = 5'b10001;
`ifdef FP_DIV_SUBNORMAL_EN
    end else if (tiny_q) begin
      // Exponent field 0; a round-up into the hidden bit lands on the
      // exponent LSB and yields field 1.
      res_pack = mode_q ? {sign_q, 7'd0, rmant[23:0]} : {16'd0, sign_q, 4'd0, rmant[10:0]};
      flg_pack = {1'b0, inexact, 2'b00, inexact};
`else
    end else if (rexp <= 12'sd0) begin
      res_pack = zero_w;
      flg_pack = 5'b01001;
`endif
    end else begin
      res_pack = mode_q ? {sign_q, rexp[7:0], rmant[22:0]}
                        : {16'd0, sign_q, rexp[4:0], rmant[9:0]};
      flg_pack = {4'd0, inexact};
    end
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    mode_d      = mode_q;
    inv_d       = inv_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
`ifdef FP_DIV_SUBNORMAL_EN
    sticky_d    = sticky_q;
    tiny_d      = tiny_q;
    shcnt_d     = shcnt_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        mant_d = MANT_IN;
        exp_d  = {{(EW-10){EXP_IN[9]}}, EXP_IN};
        sign_d = SIGN_IN;
        mode_d = MODE_FP;
        inv_d  = FLAGS_IN[1];
        dbz_d  = FLAGS_IN[2];
`ifdef FP_DIV_SUBNORMAL_EN
        sticky_d = 1'b0;
        tiny_d   = 1'b0;
        shcnt_d  = '0;
`endif
      end
      S_NORM: begin
        if (!norm_done) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 12'sd1;
        end
`ifdef FP_DIV_SUBNORMAL_EN
        else if (!special && mant_q != '0 && exp_q <= 12'sd0) tiny_d = 1'b1;
`endif
      end
`ifdef FP_DIV_SUBNORMAL_EN
      S_DENORM: if (exp_q != 12'sd1) begin
        if (shcnt_q == (mode_q ? 5'd25 : 5'd12)) begin
          // Past the cap nothing survives in the kept field: all to sticky.
          sticky_d = sticky_q | (|mant_q);
          mant_d   = '0;
          exp_d    = 12'sd1;
        end else begin
          sticky_d = sticky_q | mant_q[0];
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + 12'sd1;
          shcnt_d  = shcnt_q + 5'd1;
        end
      end
`endif
      S_ROUND: begin
        result_d    = res_pack;
        flags_d     = flg_pack;
        out_valid_d = 1'b1;
      end
      S_DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      mode_q      <= 1'b0;
      inv_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef FP_DIV_SUBNORMAL_EN
      sticky_q    <= 1'b0;
      tiny_q      <= 1'b0;
      shcnt_q     <= '0;
`endif
    end else begin
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef FP_DIV_SUBNORMAL_EN
      sticky_q    <= sticky_d;
      tiny_q      <= tiny_d;
      shcnt_q     <= shcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_div_normalize_pack.sv
// Self-checking bench for fp_div_normalize_pack (default build, flush-to-zero).
// Directed cases followed by randomized operations checked against a
// value-level reference model (leading-one position, integer remainder vs.
// half-ulp comparison for round-to-nearest-even).

module tb_fp_div_normalize_pack;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] mant_in = '0;
  logic [9:0]   exp_in = '0;
  logic         sign_in = 1'b0;
  logic         mode_fp = 1'b1;
  logic [4:0]   flags_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  result;
  logic [4:0]   flags_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_normalize_pack #(.MANT_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .MANT_IN  (mant_in),
    .EXP_IN   (exp_in),
    .SIGN_IN  (sign_in),
    .MODE_FP  (mode_fp),
    .FLAGS_IN (flags_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .RESULT   (result),
    .FLAGS_OUT(flags_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: value-level normalize / round-to-nearest-even / pack.
  task automatic ref_model(input logic [W-1:0] m, input int e, input logic s, input logic md,
                           input logic [4:0] f, output logic [31:0] r, output logic [4:0] fl,
                           output int lat);
    longint unsigned v, kept, rem, half;
    int p, k, ee, kw, drop;
    logic [31:0] inf_v, zero_v;
    inf_v  = md ? {s, 8'hFF, 23'd0} : {16'd0, s, 5'h1F, 10'd0};
    zero_v = md ? {s, 31'd0} : {16'd0, s, 15'd0};
    lat = 2;
    fl  = '0;
    r   = '0;
    if (f[1]) begin
      r  = md ? 32'h7FC0_0000 : 32'h0000_7E00;
      fl = 5'b00010;
    end else if (f[2]) begin
      r  = inf_v;
      fl = 5'b00100;
    end else if (m == '0) begin
      r = zero_v;
    end else begin
      p = 0;
      for (int i = 0; i < W; i++) if (m[i]) p = i;
      k    = W - 1 - p;
      lat  = k + 2;
      ee   = e - k;
      kw   = md ? 24 : 11;
      drop = W - kw;
      v    = 64'(m) << k;
      kept = v >> drop;
      rem  = v & ((64'd1 << drop) - 64'd1);
      half = 64'd1 << (drop - 1);
      if (rem > half || (rem == half && kept[0])) kept++;
      if (kept == (64'd1 << kw)) begin
        kept = kept >> 1;
        ee++;
      end
      if (ee >= (md ? 255 : 31)) begin
        r  = inf_v;
        fl = 5'b10001;
      end else if (ee <= 0) begin
        r  = zero_v;
        fl = 5'b01001;
      end else begin
        r  = md ? {s, ee[7:0], kept[22:0]} : {16'd0, s, ee[4:0], kept[9:0]};
        fl = {4'd0, rem != 0};
      end
    end
  endtask

  // One full transaction; 'stall' cycles of out_ready=0 after out_valid rises.
  task automatic run_op(input string tag, input logic [W-1:0] m, input int e, input logic s,
                        input logic md, input logic [4:0] f, input logic [31:0] exp_res,
                        input logic [4:0] exp_flg, input int exp_lat, input int stall);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    mant_in   = m;
    exp_in    = 10'(e);
    sign_in   = s;
    mode_fp   = md;
    flags_in  = f;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {27'd0, flags_out}, {27'd0, exp_flg});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_result"}, result, exp_res);
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  fl, f;
    logic [63:0] rnd;
    logic [W-1:0] m;
    logic        s, md;
    int          lat, e, lz;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {27'd0, flags_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("s_1p5", 48'hC000_0000_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h3FC0_0000, 5'b00000, 2, 0);
    run_op("h_1p5", 48'hC000_0000_0000, 15, 1'b0, 1'b0, 5'b00000, 32'h0000_3E00, 5'b00000, 2, 0);
    run_op("norm1", 48'h6000_0000_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h3F40_0000, 5'b00000, 3, 0);
    run_op("tie_even", 48'h8000_0080_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h3F80_0000, 5'b00001, 2, 0);
    run_op("tie_odd", 48'h8000_0180_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h3F80_0002, 5'b00001, 2, 0);
    run_op("rnd_carry", 48'hFFFF_FF80_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h4000_0000, 5'b00001, 2, 0);
    run_op("overflow", 48'hC000_0000_0000, 255, 1'b0, 1'b1, 5'b00000, 32'h7F80_0000, 5'b10001, 2, 0);
    run_op("underflow", 48'hC000_0000_0000, 0, 1'b1, 1'b1, 5'b00000, 32'h8000_0000, 5'b01001, 2, 0);
    run_op("invalid", 48'h6000_0000_0000, 127, 1'b1, 1'b1, 5'b00010, 32'h7FC0_0000, 5'b00010, 2, 0);
    run_op("inv_prio", 48'hC000_0000_0000, 127, 1'b0, 1'b0, 5'b00110, 32'h0000_7E00, 5'b00010, 2, 0);
    run_op("dbz_half", 48'h0000_0100_0000, 15, 1'b1, 1'b0, 5'b00100, 32'h0000_FC00, 5'b00100, 2, 0);
    run_op("zero", 48'h0000_0000_0000, 127, 1'b1, 1'b1, 5'b00000, 32'h8000_0000, 5'b00000, 2, 0);
    run_op("backpress", 48'hC000_0000_0000, 127, 1'b0, 1'b1, 5'b00000, 32'h3FC0_0000, 5'b00000, 2, 5);

    // Reset during NORM discards the operation
    @(negedge clk);
    mant_in  = 48'h0000_0100_0000;
    exp_in   = 10'd150;
    sign_in  = 1'b0;
    mode_fp  = 1'b1;
    flags_in = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {27'd0, flags_out}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 48'h0000_0100_0000, 150, 1'b0, 1'b1, 5'b00000, 32'h3F80_0000, 5'b00000, 25, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      md  = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      rnd = {$urandom, $urandom};
      m   = rnd[W-1:0];
      m[W-1] = 1'b1;
      lz  = $urandom_range(0, W - 1);
      m   = m >> lz;
      if ($urandom_range(0, 9) == 0) m = '0;
      e   = int'($urandom_range(0, md ? 300 : 45)) - 10;
      f   = 5'($urandom) & 5'b11001;
      if ($urandom_range(0, 9) == 0) f[1] = 1'b1;
      if ($urandom_range(0, 9) == 0) f[2] = 1'b1;
      ref_model(m, e, s, md, f, r, fl, lat);
      run_op($sformatf("rnd%0d", i), m, e, s, md, f, r, fl, lat, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_div_normalize_pack.md
Name: fp_div_normalize_pack

Overview:
- Back end of the FP divide path.
- Consumes the raw quotient mantissa, biased exponent, sign and special-case flags produced by the divide front end.
- Normalizes iteratively, rounds to nearest-even and packs an IEEE single or half result with final exception flags.
- Valid/ready handshakes on both sides; one operation in flight.

Parameters:
MANT_W, 48, quotient mantissa width in Q1.(MANT_W-1) format. Bit MANT_W-1 has weight 2^0. Must be >= 26.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept (high only in IDLE)
MANT_IN  input  MANT_W  unsigned quotient mantissa, value in [0,2)
EXP_IN  input  10  two's-complement biased exponent of the quotient
SIGN_IN  input  1  result sign
MODE_FP  input  1  0 = half, 1 = single
FLAGS_IN  input  5  front-end flags: [1] invalid, [2] divide-by-zero; other bits ignored
out_valid  output  1  RESULT/FLAGS_OUT valid
out_ready  input  1  consumer accepts result
RESULT  output  32  packed result; half mode uses [15:0], [31:16]=0
FLAGS_OUT  output  5  [0] inexact, [1] invalid, [2] div-by-zero, [3] underflow, [4] overflow

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, RESULT=0, FLAGS_OUT=0. Any operation in progress is discarded.
- FSM states: IDLE, NORM, ROUND, DONE (plus DENORM under the macro).
- IDLE: accept when in_valid && in_ready. Capture all inputs, set e = EXP_IN, go to NORM.
- NORM, exit condition: if mant==0, mant[MSB]==1, or FLAGS_IN[1]|FLAGS_IN[2], go to ROUND.
- NORM, shift: otherwise shift mant left 1 and set e = e-1, one bit per cycle.
- Latency: k = leading zeros of MANT_IN. out_valid rises k+2 cycles after the accept edge; specials and zero take 2 cycles.
- ROUND, keep width: single keeps mant[MSB -: 24], guard = the next bit, sticky = OR of the remaining bits. Half keeps 11 bits, same guard/sticky rule.
- ROUND, RNE: round up iff guard && (sticky || lsb). Carry out of the kept field sets mantissa=1.0 and e = e+1.
- ROUND, inexact: inexact = guard|sticky.
- Overflow: single e >= 255, half e >= 31. Result = signed infinity; FLAGS_OUT[4] and [0] set.
- Underflow (macro off): e <= 0 and mant != 0. Result = signed zero; FLAGS_OUT[3] and [0] set.
- Normal pack, single: {sign, e[7:0], frac23}.
- Normal pack, half: {16'b0, sign, e[4:0], frac10}.
- Zero mantissa: signed zero, FLAGS_OUT = 0.
- Invalid (FLAGS_IN[1]): single 0x7FC00000, half 0x00007E00, sign 0, FLAGS_OUT = 00010. Takes priority over divide-by-zero.
- Divide-by-zero (FLAGS_IN[2]): signed infinity, FLAGS_OUT = 00100.
- ROUND completes in 1 cycle: registers RESULT/FLAGS_OUT, sets out_valid=1, goes to DONE.
- DONE: RESULT and FLAGS_OUT are held stable while out_ready=0. On out_valid && out_ready, clear out_valid and go to IDLE. in_ready rises the following cycle; no same-cycle turnaround.
- Handshake: in_valid while in_ready=0 is ignored; the producer holds its data.

Optional Feature:
- Macro: FP_DIV_SUBNORMAL_EN.
- Defined: if e <= 0 after NORM, enter DENORM.
- DENORM shifts mant right 1 per cycle, ORing shifted-out bits into sticky, and sets e = e+1 until e == 1.
- Shifts cap at 25 (single) or 12 (half); beyond the cap all bits go to sticky.
- Then ROUND packs with exponent field 0. A carry into the hidden bit yields exponent field 1.
- FLAGS_OUT[3] is set only if tiny and inexact.
- Latency grows by the shift count.
- Undefined: flush-to-zero as described in Behaviour; DENORM is absent.

Test Plan:
- Single, MANT_IN=48'hC00000000000, EXP_IN=127, SIGN_IN=0 -> RESULT=0x3FC00000, FLAGS_OUT=0, out_valid 2 cycles after accept. Same operands with MODE_FP=0, EXP_IN=15 -> 0x00003E00.
- Single, MANT_IN=48'h600000000000, EXP_IN=127 -> one NORM shift, RESULT=0x3F400000, latency 3 cycles.
- RNE, single:
  - 48'h800000800000 (tie, lsb 0) -> 0x3F800000, FLAGS_OUT=00001.
  - 48'h800001800000 (tie, lsb 1) -> 0x3F800002.
  - 48'hFFFFFF800000 -> carry, 0x40000000.
- Single, EXP_IN=255 -> 0x7F800000, FLAGS_OUT=10001. Single, EXP_IN=0, SIGN_IN=1, macro off -> 0x80000000, FLAGS_OUT=01001.
- Single, FLAGS_IN=00010 -> 0x7FC00000, FLAGS_OUT=00010. Half, FLAGS_IN=00100, SIGN_IN=1 -> 0x0000FC00, FLAGS_OUT=00100.
- Back-pressure and reset:
  - out_ready low for 5 cycles -> RESULT stable, in_ready=0.
  - rst_n pulsed low during NORM of MANT_IN=48'h000001000000 -> out_valid=0, RESULT=0, in_ready=1; the next operation completes normally.
